xfer_host_master: RTL and testbench

XFER_HOST_MASTER -- requirements
Module: xfer_host_master

---
 rtl/xfer_pkg.sv | 32 +++
 rtl/xfer_beat_counter.sv | 30 +++
 rtl/xfer_host_master.sv | 184 ++++++++++++++++++
 tb/tb_xfer_host_master.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xfer_pkg.sv
// Shared constants and state encoding for the host page-transfer master
// and the buffer block it talks to.
package xfer_pkg;

    localparam int HDATA_WIDTH    = 32;
    localparam int UNIT_BUF_BY_4B = 1024;
    localparam int MAX_BUFQ_DEPTH = 4;
    localparam int POLL_LIMIT     = 255;
    localparam int GS_W           = 8;
    localparam int BEAT_W         = $clog2(UNIT_BUF_BY_4B) + 1;

    typedef enum logic [2:0] {
        IDLE,
        POLL_REQ,
        POLL_WAIT,
        XFER,
        DRAIN,
        DONE
    } xfer_state_t;

    // A write needs at least one free rx page; a read needs at least one
    // filled tx page, i.e. the free count must be below the queue depth.
    function automatic logic queue_ready(input logic is_write,
                                         input logic [GS_W-1:0] gs,
                                         input int depth);
        if (is_write)
            return gs != '0;
        else
            return gs != GS_W'(depth);
    endfunction

endpackage

// File: rtl/xfer_beat_counter.sv
// Page beat counter: clear, saturating increment, last-beat and
// terminal-count flags.
module xfer_beat_counter
    import xfer_pkg::*;
#(
    parameter int LIMIT = UNIT_BUF_BY_4B,
    parameter int CNT_W = BEAT_W
) (
    input  logic             clock_host,
    input  logic             reset,
    input  logic             clear,
    input  logic             incr,
    output logic [CNT_W-1:0] count,
    output logic             at_last,
    output logic             terminal
);

    assign at_last  = (count == CNT_W'(LIMIT - 1));
    assign terminal = (count == CNT_W'(LIMIT));

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clock_host) begin
        if (reset || clear)
            count <= '0;
        else if (incr && !terminal)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/xfer_host_master.sv
// Moves one page per command between the local streams and the host
// buffer, polling the buffer's free count before touching any word.
module xfer_host_master #(
    parameter int HDATA_WIDTH    = xfer_pkg::HDATA_WIDTH,
    parameter int UNIT_BUF_BY_4B = xfer_pkg::UNIT_BUF_BY_4B,
    parameter int MAX_BUFQ_DEPTH = xfer_pkg::MAX_BUFQ_DEPTH,
    parameter int POLL_LIMIT     = xfer_pkg::POLL_LIMIT
) (
    input  logic                   clock_host,
    input  logic                   reset,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,

    input  logic [HDATA_WIDTH-1:0] wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,

    output logic [HDATA_WIDTH-1:0] rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,

    output logic                   host_select,
    output logic                   hwrite_enable,
    output logic [HDATA_WIDTH-1:0] hostdata_out,
    output logic                   hostdata_oe,
    input  logic [HDATA_WIDTH-1:0] hostdata_in,

    output logic                   gs_select,
    output logic                   gs_write_enable,
    input  logic [7:0]             gs_in,
    input  logic                   gs_in_valid,

    output logic                   done,
    output logic                   done_err
);

    import xfer_pkg::*;

    localparam int CNT_W  = $clog2(UNIT_BUF_BY_4B) + 1;
    localparam int POLL_W = $clog2(POLL_LIMIT + 1);

    xfer_state_t       state, state_nxt;
    logic              is_write;
    logic              err_flag;
    logic [POLL_W-1:0] poll_cnt;
    logic [POLL_W-1:0] poll_cnt_nxt;
    logic              accept;
    logic              poll_fail;
    logic              poll_abort;

    logic              beat;
    logic              beat_clear;
    logic [CNT_W-1:0]  beat_count;
    logic              beat_last;
    logic              beat_terminal;

    assign accept       = (state == IDLE) && cmd_valid;
    assign poll_cnt_nxt = poll_cnt + 1'b1;
    assign poll_fail    = (state == POLL_WAIT) && gs_in_valid
                          && !queue_ready(is_write, gs_in, MAX_BUFQ_DEPTH);
    assign poll_abort   = poll_fail && (poll_cnt_nxt == POLL_W'(POLL_LIMIT));

    xfer_beat_counter #(
        .LIMIT (UNIT_BUF_BY_4B),
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clock_host (clock_host),
        .reset      (reset),
        .clear      (beat_clear),
        .incr       (beat),
        .count      (beat_count),
        .at_last    (beat_last),
        .terminal   (beat_terminal)
    );

    always_ff @(posedge clock_host) begin
        if (reset) begin
            state    <= IDLE;
            is_write <= 1'b0;
            err_flag <= 1'b0;
            poll_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                is_write <= cmd_write;
                err_flag <= 1'b0;
                poll_cnt <= '0;
            end else if (poll_fail) begin
                poll_cnt <= poll_cnt_nxt;
                if (poll_abort)
                    err_flag <= 1'b1;
            end
        end
    end

    // Read return path: one word back per issued read strobe, one cycle
    // later. The data register is reset too so rd_data reads 0 after reset.
    always_ff @(posedge clock_host) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= host_select && !hwrite_enable;
            if (host_select && !hwrite_enable)
                rd_data <= hostdata_in;
        end
    end

    // NOTE: every output of this block is given a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt       = state;
        cmd_ready       = 1'b0;
        gs_select       = 1'b0;
        gs_write_enable = 1'b0;
        host_select     = 1'b0;
        hwrite_enable   = 1'b0;
        hostdata_oe     = 1'b0;
        hostdata_out    = '0;
        wr_ready        = 1'b0;
        done            = 1'b0;
        done_err        = 1'b0;
        beat            = 1'b0;
        beat_clear      = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    beat_clear = 1'b1;
                    state_nxt  = POLL_REQ;
                end
            end
            POLL_REQ: begin
                gs_select       = 1'b1;
                gs_write_enable = is_write;
                state_nxt       = POLL_WAIT;
            end
            POLL_WAIT: begin
                if (gs_in_valid) begin
                    if (!poll_fail)
                        state_nxt = XFER;
                    else if (poll_abort)
                        state_nxt = DONE;
                    else
                        state_nxt = POLL_REQ;
                end
            end
            XFER: begin
                if (is_write) begin
                    wr_ready = 1'b1;
                    if (wr_valid && !beat_terminal) begin
                        beat          = 1'b1;
                        host_select   = 1'b1;
                        hwrite_enable = 1'b1;
                        hostdata_oe   = 1'b1;
                        hostdata_out  = wr_data;
                        if (beat_last)
                            state_nxt = DONE;
                    end
                end else if (rd_ready && !beat_terminal) begin
                    beat        = 1'b1;
                    host_select = 1'b1;
                    if (beat_last)
                        state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                done_err  = err_flag;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_xfer_host_master.sv
// Directed bench for xfer_host_master with a status responder and a
// buffer that returns its running read address as data.
module tb_xfer_host_master;

    localparam int WORDS = 1024;

    logic        clock_host = 1'b0;
    logic        reset      = 1'b1;
    logic        cmd_valid  = 1'b0;
    logic        cmd_ready;
    logic        cmd_write  = 1'b0;
    logic [31:0] wr_data    = '0;
    logic        wr_valid   = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready   = 1'b0;
    logic        host_select;
    logic        hwrite_enable;
    logic [31:0] hostdata_out;
    logic        hostdata_oe;
    logic [31:0] hostdata_in;
    logic        gs_select;
    logic        gs_write_enable;
    logic [7:0]  gs_in;
    logic        gs_in_valid;
    logic        done;
    logic        done_err;

    logic [7:0]  gs_reply  = '0;
    logic        buf_clear = 1'b0;
    logic [31:0] rd_ptr;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock_host = ~clock_host;

    xfer_host_master dut (
        .clock_host      (clock_host),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .host_select     (host_select),
        .hwrite_enable   (hwrite_enable),
        .hostdata_out    (hostdata_out),
        .hostdata_oe     (hostdata_oe),
        .hostdata_in     (hostdata_in),
        .gs_select       (gs_select),
        .gs_write_enable (gs_write_enable),
        .gs_in           (gs_in),
        .gs_in_valid     (gs_in_valid),
        .done            (done),
        .done_err        (done_err)
    );

    // Status responder answers one cycle after each query; buffer returns
    // its read pointer as data and advances it on every read strobe.
    assign hostdata_in = rd_ptr;

    always @(posedge clock_host) begin
        if (reset) begin
            gs_in_valid <= 1'b0;
            gs_in       <= '0;
        end else begin
            gs_in_valid <= gs_select;
            if (gs_select)
                gs_in <= gs_reply;
        end
        if (buf_clear)
            rd_ptr <= '0;
        else if (host_select && !hwrite_enable)
            rd_ptr <= rd_ptr + 1;
    end

    task automatic issue_cmd(input logic write);
        @(negedge clock_host);
        cmd_write = write;
        cmd_valid = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        @(posedge clock_host);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock_host);
        #1;
        vectors++;
        if ({cmd_ready, host_select, hwrite_enable, hostdata_oe, gs_select, gs_write_enable,
             wr_ready, rd_valid, done, done_err} !== 10'b10_0000_0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 1000000000",
                     {cmd_ready, host_select, hwrite_enable, hostdata_oe, gs_select,
                      gs_write_enable, wr_ready, rd_valid, done, done_err});
        end
        vectors++;
        if (hostdata_out !== 32'h0 || rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: hostdata_out %h rd_data %h want 0", hostdata_out, rd_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_write(input bit toggle, input int fail_polls);
        int idx = 0, polls = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
        bit got_done = 0, tgl = 1;
        issue_cmd(1'b1);
        while (!got_done && cyc < 6000) begin
            @(negedge clock_host);
            gs_reply = (polls < fail_polls) ? 8'd0 : 8'd4;
            wr_valid = toggle ? tgl : 1'b1;
            tgl      = ~tgl;
            wr_data  = 32'(idx);
            #1;
            if (gs_select) begin
                polls++;
                vectors++;
                if (gs_write_enable !== 1'b1 || host_select !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wr_poll: gs_we %b host_sel %b want 1 0", gs_write_enable, host_select);
                end
            end
            if (wr_ready && !wr_valid) begin
                vectors++;
                if (host_select !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wr_stall: host_select %b want 0 at cycle %0d", host_select, cyc);
                end
            end
            if (host_select) begin
                vectors++;
                if ({hwrite_enable, hostdata_oe, wr_valid} !== 3'b111 || hostdata_out !== 32'(idx)) begin
                    miscompares++;
                    $display("FAIL wr_beat: we/oe %b%b data %0d want 11 %0d",
                             hwrite_enable, hostdata_oe, hostdata_out, idx);
                end
                if (idx == 0) first_cyc = cyc;
                last_cyc = cyc;
                idx++;
            end
            if (done) begin
                got_done = 1;
                vectors++;
                if (done_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wr_done_err: got %b want 0", done_err);
                end
            end
            cyc++;
        end
        wr_valid = 1'b0;
        vectors++;
        if (!got_done || idx != WORDS || polls != fail_polls + 1) begin
            miscompares++;
            $display("FAIL wr_page: done %0d beats %0d polls %0d want 1 %0d %0d",
                     got_done, idx, polls, WORDS, fail_polls + 1);
        end
        vectors++;
        if (last_cyc - first_cyc + 1 != (toggle ? 2047 : WORDS)) begin
            miscompares++;
            $display("FAIL wr_span: got %0d cycles want %0d",
                     last_cyc - first_cyc + 1, toggle ? 2047 : WORDS);
        end
    endtask

    task automatic test_read(input bit gap, input int fail_polls);
        int strobes = 0, words = 0, polls = 0, cyc = 0, last_strobe = 0, gap_cnt = 0;
        bit got_done = 0, prev_strobe = 0;
        @(negedge clock_host) buf_clear = 1'b1;
        @(negedge clock_host) buf_clear = 1'b0;
        issue_cmd(1'b0);
        while (!got_done && cyc < 6000) begin
            @(negedge clock_host);
            gs_reply = (polls < fail_polls) ? 8'd4 : 8'd3;
            rd_ready = !(gap && strobes >= 500 && gap_cnt < 10);
            if (!rd_ready) gap_cnt++;
            #1;
            if (gs_select) begin
                polls++;
                vectors++;
                if (gs_write_enable !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rd_poll: gs_we %b want 0", gs_write_enable);
                end
            end
            if (host_select) begin
                vectors++;
                if (hwrite_enable !== 1'b0 || hostdata_oe !== 1'b0 || rd_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rd_strobe: we %b oe %b rd_ready %b want 0 0 1",
                             hwrite_enable, hostdata_oe, rd_ready);
                end
                strobes++;
                last_strobe = cyc;
            end
            vectors++;
            if (rd_valid !== prev_strobe || (gap_cnt > 1 && !rd_ready && rd_valid)) begin
                miscompares++;
                $display("FAIL rd_latency: rd_valid %b want %b at cycle %0d", rd_valid, prev_strobe, cyc);
            end
            if (rd_valid) begin
                vectors++;
                if (rd_data !== 32'(words)) begin
                    miscompares++;
                    $display("FAIL rd_word: got %0d want %0d", rd_data, words);
                end
                words++;
            end
            if (done) begin
                got_done = 1;
                vectors++;
                if (done_err !== 1'b0 || cyc - last_strobe != 2) begin
                    miscompares++;
                    $display("FAIL rd_done: err %b gap %0d want 0 2", done_err, cyc - last_strobe);
                end
            end
            prev_strobe = host_select;
            cyc++;
        end
        rd_ready = 1'b0;
        vectors++;
        if (!got_done || strobes != WORDS || words != WORDS || polls != fail_polls + 1) begin
            miscompares++;
            $display("FAIL rd_page: done %0d strobes %0d words %0d polls %0d want 1 %0d %0d %0d",
                     got_done, strobes, words, polls, WORDS, WORDS, fail_polls + 1);
        end
    endtask

    task automatic test_poll_abort(input logic write);
        int polls = 0, strobes = 0, cyc = 0;
        bit got_done = 0;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        issue_cmd(write);
        while (!got_done && cyc < 1000) begin
            @(negedge clock_host);
            gs_reply = write ? 8'd0 : 8'd4;
            #1;
            if (gs_select) polls++;
            if (host_select) strobes++;
            if (done) begin
                got_done = 1;
                vectors++;
                if (done_err !== 1'b1) begin
                    miscompares++;
                    $display("FAIL abort_err: done_err %b want 1", done_err);
                end
            end
            cyc++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        vectors++;
        if (!got_done || polls != 255 || strobes != 0) begin
            miscompares++;
            $display("FAIL abort_page: done %0d polls %0d strobes %0d want 1 255 0",
                     got_done, polls, strobes);
        end
    endtask

    task automatic test_reset_mid();
        int idx = 0, cyc = 0, stray = 0;
        issue_cmd(1'b1);
        while (idx < 500 && cyc < 2000) begin
            @(negedge clock_host);
            gs_reply = 8'd4;
            wr_valid = 1'b1;
            wr_data  = 32'(idx);
            #1;
            if (host_select) idx++;
            cyc++;
        end
        @(negedge clock_host);
        reset = 1'b1;
        @(negedge clock_host);
        #1;
        vectors++;
        if ({cmd_ready, host_select, hwrite_enable, hostdata_oe, gs_select, gs_write_enable,
             wr_ready, rd_valid, done, done_err} !== 10'b10_0000_0000) begin
            miscompares++;
            $display("FAIL midreset_ctrl: got %b want 1000000000",
                     {cmd_ready, host_select, hwrite_enable, hostdata_oe, gs_select,
                      gs_write_enable, wr_ready, rd_valid, done, done_err});
        end
        vectors++;
        if (hostdata_out !== 32'h0 || rd_data !== 32'h0 || idx != 500) begin
            miscompares++;
            $display("FAIL midreset_data: hostdata_out %h rd_data %h beats %0d want 0 0 500",
                     hostdata_out, rd_data, idx);
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge clock_host);
            #1;
            if (done || host_select || gs_select) stray++;
        end
        wr_valid = 1'b0;
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("FAIL midreset_idle: %0d active cycles want 0", stray);
        end
        test_write(1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_write(1'b0, 0);
        test_write(1'b1, 2);
        test_read(1'b0, 0);
        test_read(1'b1, 1);
        test_poll_abort(1'b1);
        test_poll_abort(1'b0);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
